// File: rtl/rc_arb_pkg.sv
// Shared types for the ring-controller access arbiter: FSM state and
// transaction completion status.
package rc_arb_pkg;

  localparam int unsigned RC_ADDR_W = 32;
  localparam int unsigned RC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    DONE
  } arb_state_t;

  typedef enum logic {
    ST_OK,
    ST_TIMEOUT
  } arb_status_t;

endpackage

// File: rtl/counter.sv
// Loadable up-counter with enable; load has priority over enable and the
// count wraps at 2**WIDTH.
module counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (enable_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward
// from last_grant+1 with wrap-around.
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W_IDX = 1
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [W_IDX-1:0] last_grant_i,
  output logic             any_o,
  output logic [W_IDX-1:0] winner_o
);

  logic [N_REQ-1:0] above_mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] cand;

  // NOTE: every signal gets a default at the top of the always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    any_o      = |req_valid_i;
    winner_o   = '0;
    // Requests strictly above the last grant win; otherwise wrap to the bottom.
    above_mask = {N_REQ{1'b1}} << (int'(last_grant_i) + 1);
    masked     = req_valid_i & above_mask;
    cand       = (|masked) ? masked : req_valid_i;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner_o = W_IDX'(i);
      end
    end
  end

endmodule

// File: rtl/rc_access_arbiter.sv
// Round-robin arbiter sharing one ring-controller request port among N_REQ
// requesters, with one outstanding transaction and a response timeout.
module rc_access_arbiter
  import rc_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ-1:0]               req_write,
  input  logic [N_REQ-1:0][RC_ADDR_W-1:0] req_address,
  input  logic [N_REQ-1:0][RC_DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]               req_ack,
  output logic [N_REQ-1:0]               resp_valid,
  output logic [N_REQ-1:0]               resp_timeout,
  output logic [RC_DATA_W-1:0]           resp_data,
  output logic                           busy,
  output logic                           stray_resp,
  output logic                           rc_write_valid,
  output logic                           rc_read_valid,
  output logic [RC_ADDR_W-1:0]           rc_address,
  output logic [RC_DATA_W-1:0]           rc_data_out,
  input  logic [RC_DATA_W-1:0]           rc_data_in,
  input  logic                           rc_write_resp_valid,
  input  logic                           rc_read_resp_valid
);

  localparam int unsigned W_IDX = $clog2(N_REQ);
  localparam int unsigned W_CNT = $clog2(TIMEOUT_CYCLES);
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TIMEOUT_CYCLES - 1);

  arb_state_t           state_q;
  arb_status_t          status_q;
  logic [W_IDX-1:0]     grant_q;
  logic [W_IDX-1:0]     last_grant_q;
  logic                 write_q;
  logic [RC_ADDR_W-1:0] rc_address_q;
  logic [RC_DATA_W-1:0] rc_data_q;
  logic [RC_DATA_W-1:0] resp_data_q;
  logic                 rc_write_valid_q;
  logic                 rc_read_valid_q;

  logic                 pick_any;
  logic [W_IDX-1:0]     pick_winner;
  logic [W_CNT-1:0]     wait_cnt;
  logic                 in_wait;
  logic                 resp_match;
  logic                 timeout_hit;
  logic [N_REQ-1:0]     grant_oh;

  rr_pick #(
    .N_REQ (N_REQ),
    .W_IDX (W_IDX)
  ) u_rr_pick (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .winner_o     (pick_winner)
  );

  counter #(
    .WIDTH (W_CNT)
  ) u_timeout_cnt (
    .clk          (clk),
    .rstn         (rstn),
    .load_i       (state_q == ISSUE),
    .load_value_i ('0),
    .enable_i     (in_wait),
    .count_o      (wait_cnt)
  );

  assign in_wait     = (state_q == WAIT_RESP);
  assign resp_match  = write_q ? rc_write_resp_valid : rc_read_resp_valid;
  assign timeout_hit = (wait_cnt == CNT_LAST);
  assign grant_oh    = N_REQ'(1) << grant_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= IDLE;
      status_q         <= ST_OK;
      grant_q          <= '0;
      last_grant_q     <= W_IDX'(N_REQ - 1);
      write_q          <= 1'b0;
      rc_address_q     <= '0;
      rc_data_q        <= '0;
      resp_data_q      <= '0;
      rc_write_valid_q <= 1'b0;
      rc_read_valid_q  <= 1'b0;
    end else begin
      rc_write_valid_q <= 1'b0;
      rc_read_valid_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q          <= pick_winner;
            write_q          <= req_write[pick_winner];
            rc_address_q     <= req_address[pick_winner];
            rc_data_q        <= req_data[pick_winner];
            rc_write_valid_q <= req_write[pick_winner];
            rc_read_valid_q  <= ~req_write[pick_winner];
            state_q          <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT_RESP;
        end
        WAIT_RESP: begin
          // A matching response on the final cycle still counts as success.
          if (resp_match) begin
            status_q <= ST_OK;
            if (!write_q) begin
              resp_data_q <= rc_data_in;
            end
            state_q <= DONE;
          end else if (timeout_hit) begin
            status_q    <= ST_TIMEOUT;
            resp_data_q <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ack      = (state_q == IDLE && pick_any) ? (N_REQ'(1) << pick_winner) : '0;
  assign resp_valid   = (state_q == DONE && status_q == ST_OK) ? grant_oh : '0;
  assign resp_timeout = (state_q == DONE && status_q == ST_TIMEOUT) ? grant_oh : '0;
  assign busy         = (state_q != IDLE);

  // Any response not consumed as the matching completion is reported as stray.
  assign stray_resp = (rc_write_resp_valid && !(in_wait && write_q)) ||
                      (rc_read_resp_valid  && !(in_wait && !write_q));

  assign rc_write_valid = rc_write_valid_q;
  assign rc_read_valid  = rc_read_valid_q;
  assign rc_address     = rc_address_q;
  assign rc_data_out    = rc_data_q;
  assign resp_data      = resp_data_q;

endmodule

// File: tb/tb_rc_access_arbiter.sv
// Self-checking bench for rc_access_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_rc_access_arbiter;

  localparam int N  = 3;
  localparam int TC = 8;

  logic                 clk;
  logic                 rstn;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_write;
  logic [N-1:0][31:0]   req_address;
  logic [N-1:0][31:0]   req_data;
  logic [N-1:0]         req_ack;
  logic [N-1:0]         resp_valid;
  logic [N-1:0]         resp_timeout;
  logic [31:0]          resp_data;
  logic                 busy;
  logic                 stray_resp;
  logic                 rc_write_valid;
  logic                 rc_read_valid;
  logic [31:0]          rc_address;
  logic [31:0]          rc_data_out;
  logic [31:0]          rc_data_in;
  logic                 rc_write_resp_valid;
  logic                 rc_read_resp_valid;

  rc_access_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .req_valid           (req_valid),
    .req_write           (req_write),
    .req_address         (req_address),
    .req_data            (req_data),
    .req_ack             (req_ack),
    .resp_valid          (resp_valid),
    .resp_timeout        (resp_timeout),
    .resp_data           (resp_data),
    .busy                (busy),
    .stray_resp          (stray_resp),
    .rc_write_valid      (rc_write_valid),
    .rc_read_valid       (rc_read_valid),
    .rc_address          (rc_address),
    .rc_data_out         (rc_data_out),
    .rc_data_in          (rc_data_in),
    .rc_write_resp_valid (rc_write_resp_valid),
    .rc_read_resp_valid  (rc_read_resp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [N-1:0] ack_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_active = 0;
  bit          m_wr, m_ok;
  int          m_accept, m_idx;
  int          m_end  = -1;
  int          m_last = N - 1;
  logic [31:0] m_resp_data = '0;
  logic [31:0] m_rc_addr   = '0;
  logic [31:0] m_rc_data   = '0;

  logic [N-1:0] e_ack, e_rv, e_rt;
  bit e_busy, e_wv, e_rdv, e_stray, found, fin, is_done, match;
  int win, rel;

  always @(negedge clk) begin
    ack_prev = req_ack;
    if (!rstn) begin
      m_active = 0; m_end = -1; m_last = N - 1;
      m_resp_data = '0; m_rc_addr = '0; m_rc_data = '0;
      check("rst_busy", busy, 0);
      check("rst_rc_pulses", {rc_write_valid, rc_read_valid}, 0);
      check("rst_resp_pulses", {resp_valid, resp_timeout}, 0);
      check("rst_rc_address", rc_address, 0);
      check("rst_resp_data", resp_data, 0);
    end else begin
      e_ack = '0; e_rv = '0; e_rt = '0;
      e_busy = 0; e_wv = 0; e_rdv = 0; found = 0; fin = 0; is_done = 0; match = 0;
      win = 0; rel = 0;
      e_stray = rc_write_resp_valid | rc_read_resp_valid;
      if (!m_active) begin
        for (int k = 1; k <= N; k++) begin
          if (!found && req_valid[(m_last + k) % N]) begin
            found = 1;
            win = (m_last + k) % N;
          end
        end
        if (found) e_ack[win] = 1'b1;
      end else begin
        e_busy = 1;
        rel = cyc - m_accept;
        if (rel == 1) begin
          e_wv  = m_wr;
          e_rdv = !m_wr;
        end else if (m_end < 0) begin
          match   = m_wr ? rc_write_resp_valid : rc_read_resp_valid;
          e_stray = m_wr ? rc_read_resp_valid : rc_write_resp_valid;
          fin     = match || (rel == TC + 1);
        end else begin
          is_done = 1;
          e_rv[m_idx] = m_ok;
          e_rt[m_idx] = !m_ok;
        end
      end

      check("req_ack", req_ack, e_ack);
      check("busy", busy, e_busy);
      check("rc_write_valid", rc_write_valid, e_wv);
      check("rc_read_valid", rc_read_valid, e_rdv);
      check("resp_valid", resp_valid, e_rv);
      check("resp_timeout", resp_timeout, e_rt);
      check("stray_resp", stray_resp, e_stray);
      check("rc_address", rc_address, m_rc_addr);
      check("rc_data_out", rc_data_out, m_rc_data);
      check("resp_data", resp_data, m_resp_data);

      if (!m_active && found) begin
        m_active = 1; m_accept = cyc; m_idx = win; m_end = -1;
        m_wr = req_write[win];
        m_rc_addr = req_address[win];
        m_rc_data = req_data[win];
      end else if (fin) begin
        m_end = cyc;
        m_ok  = match;
        if (!match) m_resp_data = '0;
        else if (!m_wr) m_resp_data = rc_data_in;
      end else if (is_done) begin
        m_active = 0; m_last = m_idx; m_end = -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_request(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    tick();
    req_valid[r] = 1'b1; req_write[r] = wr; req_address[r] = a; req_data[r] = d;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (req_ack[r]) ok = 1;
      tick();
    end
    req_valid[r] = 1'b0;
    check($sformatf("ack_seen_req%0d", r), ok, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not terminate in time");
    $fatal(1);
  end

  int  g;
  bit  got;
  int  pend_at;
  bit  pend_wr;

  initial begin
    rstn = 1'b0;
    req_valid = '0; req_write = '0; req_address = '0; req_data = '0;
    rc_data_in = '0; rc_write_resp_valid = 1'b0; rc_read_resp_valid = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Single read, RC answers 3 cycles after the read pulse.
    do_request(0, 1'b0, 32'h0000_1000, 32'h0);
    @(negedge clk);
    check("t1_read_pulse", rc_read_valid, 1);
    check("t1_address", rc_address, 32'h0000_1000);
    repeat (3) tick();
    rc_read_resp_valid = 1'b1; rc_data_in = 32'hDEAD_BEEF;
    tick();
    rc_read_resp_valid = 1'b0; rc_data_in = '0;
    @(negedge clk);
    check("t1_resp_valid", resp_valid, 3'b001);
    check("t1_resp_data", resp_data, 32'hDEAD_BEEF);

    // Two requesters writing continuously: grants alternate, starting with 1.
    tick();
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_address[0] = 32'hA000_0000; req_data[0] = 32'h1111;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_address[1] = 32'hB000_0000; req_data[1] = 32'h2222;
    for (int t = 0; t < 4; t++) begin
      got = 0; g = -1;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (|req_ack) begin
          got = 1;
          g = req_ack[1] ? 1 : 0;
        end else begin
          tick();
        end
      end
      check("pp_ack_seen", got, 1);
      check($sformatf("pp_grant%0d", t), g, (t % 2 == 0) ? 1 : 0);
      tick();
      @(negedge clk);
      check($sformatf("pp_addr%0d", t), rc_address, (t % 2 == 0) ? 32'hB000_0000 : 32'hA000_0000);
      tick();
      rc_write_resp_valid = 1'b1;
      tick();
      rc_write_resp_valid = 1'b0;
    end
    req_valid = '0;

    // Read with no response: timeout TC+1 cycles after the read pulse.
    do_request(0, 1'b0, 32'h0000_2000, 32'h0);
    @(negedge clk);
    check("t3_read_pulse", rc_read_valid, 1);
    repeat (TC) tick();
    @(negedge clk);
    check("t3_not_yet", resp_timeout, 0);
    tick();
    @(negedge clk);
    check("t3_timeout", resp_timeout, 3'b001);
    check("t3_resp_valid", resp_valid, 0);
    check("t3_resp_data", resp_data, 0);
    do_request(1, 1'b1, 32'h0000_3000, 32'h0000_00AA);
    @(negedge clk);
    check("t3_next_write_pulse", rc_write_valid, 1);
    tick();
    rc_write_resp_valid = 1'b1;
    tick();
    rc_write_resp_valid = 1'b0;
    @(negedge clk);
    check("t3_next_resp", resp_valid, 3'b010);

    // Wrong-type response during a write is stray; the write still completes.
    do_request(0, 1'b1, 32'h0000_4000, 32'h0000_0055);
    tick();
    rc_read_resp_valid = 1'b1;
    @(negedge clk);
    check("t4_stray", stray_resp, 1);
    check("t4_busy", busy, 1);
    tick();
    rc_read_resp_valid = 1'b0; rc_write_resp_valid = 1'b1;
    @(negedge clk);
    check("t4_match_not_stray", stray_resp, 0);
    tick();
    rc_write_resp_valid = 1'b0;
    @(negedge clk);
    check("t4_resp_valid", resp_valid, 3'b001);

    // Response on the final timeout cycle wins over the timeout.
    do_request(0, 1'b0, 32'h0000_5000, 32'h0);
    repeat (TC) tick();
    rc_read_resp_valid = 1'b1; rc_data_in = 32'h1234_5678;
    tick();
    rc_read_resp_valid = 1'b0; rc_data_in = '0;
    @(negedge clk);
    check("t5_resp_valid", resp_valid, 3'b001);
    check("t5_no_timeout", resp_timeout, 0);
    check("t5_resp_data", resp_data, 32'h1234_5678);

    // Reset during WAIT_RESP, late response afterwards, priority back to 0.
    do_request(1, 1'b0, 32'h0000_6000, 32'h0);
    tick();
    tick();
    rstn = 1'b0;
    @(negedge clk);
    check("t6_busy_in_reset", busy, 0);
    tick();
    rstn = 1'b1;
    tick();
    rc_read_resp_valid = 1'b1; rc_data_in = 32'hCAFE_F00D;
    @(negedge clk);
    check("t6_late_stray", stray_resp, 1);
    check("t6_busy", busy, 0);
    check("t6_no_resp", {resp_valid, resp_timeout}, 0);
    tick();
    rc_read_resp_valid = 1'b0;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_address[0] = 32'h0000_7000;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_address[1] = 32'h0000_8000;
    @(negedge clk);
    check("t6_first_grant", req_ack, 3'b001);

    // Randomized traffic checked by the model on every cycle.
    pend_at = -1; pend_wr = 0;
    for (int n = 0; n < 4000; n++) begin
      tick();
      rc_write_resp_valid = 1'b0;
      rc_read_resp_valid  = 1'b0;
      rc_data_in = $urandom;
      rstn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      for (int r = 0; r < N; r++) begin
        if (ack_prev[r]) req_valid[r] = 1'b0;
        if (!req_valid[r]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[r]   = 1'b1;
            req_write[r]   = 1'($urandom_range(0, 1));
            req_address[r] = $urandom;
            req_data[r]    = $urandom;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
      if (rc_read_valid || rc_write_valid) begin
        pend_wr = rc_write_valid;
        pend_at = ($urandom_range(0, 7) == 0) ? -1 : cyc + int'($urandom_range(1, TC + 3));
      end
      if (pend_at == cyc) begin
        if ($urandom_range(0, 9) == 0) begin
          rc_write_resp_valid = !pend_wr;
          rc_read_resp_valid  = pend_wr;
        end else begin
          rc_write_resp_valid = pend_wr;
          rc_read_resp_valid  = !pend_wr;
        end
        pend_at = -1;
      end else if ($urandom_range(0, 79) == 0) begin
        rc_read_resp_valid  = 1'($urandom_range(0, 1));
        rc_write_resp_valid = !rc_read_resp_valid;
      end
    end

    tick();
    rstn = 1'b1;
    req_valid = '0;
    rc_write_resp_valid = 1'b0;
    rc_read_resp_valid  = 1'b0;
    repeat (2 * TC + 8) tick();
    @(negedge clk);
    check("final_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc_access_arbiter.md
Name: rc_access_arbiter

Overview:
Shares the single ring-controller (RC) read/write request port between N_REQ requesters. Requester 0 is the UART transfer handler engine; others are, e.g., a debug or DMA master. Arbitration is round-robin, with one outstanding transaction at a time. The arbiter owns response routing and a per-transaction response timeout, so requesters never hang on a lost RC response.

Parameters:
N_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 32, cycles waited for an RC response before declaring a timeout (>=2)
W_IDX, $clog2(N_REQ), grant index width (derived, not overridable)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  N_REQ  level request per requester; held until req_ack
req_write  in  N_REQ  1=write, 0=read, per requester
req_address  in  N_REQ x 32  request address per requester
req_data  in  N_REQ x 32  write data per requester
req_ack  out  N_REQ  one-hot one-cycle pulse: request accepted
resp_valid  out  N_REQ  one-hot one-cycle pulse: transaction completed
resp_timeout  out  N_REQ  one-hot one-cycle pulse: transaction timed out
resp_data  out  32  read data, valid with resp_valid/resp_timeout
busy  out  1  transaction in flight (state != IDLE)
stray_resp  out  1  one-cycle pulse: RC response received outside WAIT_RESP or of the wrong type
rc_write_valid  out  1  one-cycle write request pulse to RC
rc_read_valid  out  1  one-cycle read request pulse to RC
rc_address  out  32  latched address to RC
rc_data_out  out  32  latched write data to RC
rc_data_in  in  32  RC read data
rc_write_resp_valid  in  1  RC write completion pulse
rc_read_resp_valid  in  1  RC read-data-valid pulse

Behaviour:
- Reset values: all pulse outputs 0; rc_address, rc_data_out and resp_data = 0; state = IDLE; last_grant = N_REQ-1, so requester 0 has first priority.
- Round-robin pick: the winner is the first asserted req_valid scanning last_grant+1, last_grant+2, ... with modulo-N_REQ wrap.
- IDLE state:
  - If any req_valid is set, req_ack[winner] asserts combinationally in the same cycle.
  - Grant index, req_write, req_address and req_data are registered; next state is ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE state (single cycle):
  - Pulse rc_write_valid if the latched write flag is 1, else rc_read_valid.
  - rc_address and rc_data_out are stable from this cycle until the next grant.
  - Load the timeout counter to 0; go to WAIT_RESP.
- WAIT_RESP state:
  - The counter increments every cycle.
  - A matching response (rc_write_resp_valid for a write, rc_read_resp_valid for a read) sends the FSM to DONE with status OK. For a read, rc_data_in is captured into resp_data.
  - When the counter reaches TIMEOUT_CYCLES-1 with no matching response, go to DONE with status TIMEOUT; resp_data is forced to 0.
  - A matching response arriving in the same cycle as the timeout is treated as OK (the response wins).
  - A wrong-type response is ignored for completion and pulses stray_resp.
- DONE state (single cycle):
  - Pulse resp_valid[grant] for OK, or resp_timeout[grant] for TIMEOUT.
  - Update last_grant to the current grant; go to IDLE.
  - resp_data holds its value until the next read or timeout completion.
- Latency:
  - Request is accepted in cycle T (IDLE).
  - RC request pulse occurs at T+1.
  - A response at cycle R (R >= T+2) gives resp_valid at R+1.
  - A new grant is possible at R+2.
  - Minimum turnaround is 4 cycles per transaction.
- Any RC response while in IDLE, ISSUE or DONE is ignored and pulses stray_resp.
- Requester protocol:
  - A requester must keep req_valid and its payload stable until req_ack.
  - Dropping req_valid before req_ack withdraws the request; no grant occurs.
  - req_valid asserted again in the same cycle as the DONE pulse is eligible in the following IDLE cycle.
- Only one transaction is outstanding; no queueing.
- Reset mid-transaction: immediate return to IDLE. No resp_valid or resp_timeout is emitted for the aborted transaction. A late RC response after reset is reported as stray_resp.

Decomposition:
- Package rc_arb_pkg: arb_state enum {IDLE, ISSUE, WAIT_RESP, DONE} and the status enum {ST_OK, ST_TIMEOUT}.
- The timeout counter is an instance of the team's existing Counter with width $clog2(TIMEOUT_CYCLES): load = ISSUE, enable = WAIT_RESP.
- Sub-module rr_pick (combinational round-robin picker): inputs req_valid and last_grant; outputs any and winner index.

Test Plan:
- Single read from req 0, addr 0x0000_1000; RC returns 0xDEADBEEF 3 cycles after rc_read_valid -> req_ack[0] at T, rc_read_valid at T+1, resp_valid[0] with resp_data=0xDEADBEEF at T+5.
- Both requesters assert writes continuously -> grants alternate 0,1,0,1; rc_address tracks each requester's address; no two rc_*_valid pulses without an intervening DONE.
- Read with no RC response -> resp_timeout[0] exactly TIMEOUT_CYCLES+1 cycles after rc_read_valid; resp_data=0; next request granted normally.
- Write outstanding, RC sends rc_read_resp_valid -> stray_resp pulses and WAIT_RESP continues; a later rc_write_resp_valid -> resp_valid.
- Response on the final timeout cycle -> resp_valid, not resp_timeout.
- rstn asserted during WAIT_RESP, then RC response after release -> no resp pulse, stray_resp=1, busy=0; the first grant after reset goes to requester 0.
